// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, sequencer state encoding, step count.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    // ALU function codes understood by the shared combinational ALU.
    localparam logic [5:0] FUNC_ADD = 6'b000010;
    localparam logic [5:0] FUNC_SUB = 6'b000100;

    // Default iteration count for a 32-bit operand.
    localparam int STEPS_DEF = 32;

    // Multiply/divide sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/alu.sv
// Purpose: 32-bit combinational ALU (add / subtract) shared by the CPU datapath.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs continuously.
// Ports: func_i selects the operation, a_i/b_i operands, y_o result,
//        c32_o carry-out (add: carry, sub: 1 = no borrow).
module alu
    import alu_pkg::*;
(
    input  logic [5:0]  func_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o,
    output logic        c32_o
);

    logic [32:0] sum;

    always_comb begin
        sum = 33'd0;
        case (func_i)
            FUNC_ADD: sum = {1'b0, a_i} + {1'b0, b_i};
            // Two's-complement subtract; bit 32 set means a_i >= b_i.
            FUNC_SUB: sum = {1'b0, a_i} + {1'b0, ~b_i} + 33'd1;
            default:  sum = {1'b0, a_i};
        endcase
    end

    assign y_o   = sum[31:0];
    assign c32_o = sum[32];

endmodule

// File: rtl/muldiv_seq.sv
// Purpose: iterative 32-bit unsigned MULTU/DIVU using the shared ALU, one add/sub per cycle.
// Latency: start sampled at edge N, hi/lo valid from edge N+STEPS, done pulses the following cycle.
// Backpressure: start ignored while busy; a start in the DONE cycle is accepted back-to-back.
// Ports: start/op_div/opa/opb launch an op; alu_a/alu_b/alu_func drive the ALU while
//        alu_own=1 and alu_o/alu_err return its result; busy/done/dz status; hi/lo result.
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int STEPS = STEPS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_div,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic [31:0] alu_o,
    input  logic        alu_err,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_func,
    output logic        alu_own,
    output logic        busy,
    output logic        done,
    output logic        dz,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(STEPS);
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    md_state_t     state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   mcand_q, mcand_d;
    logic          op_div_q, op_div_d;
    logic          dz_q, dz_d;

    // Restoring-division partial remainder shifted left by one, pulling in the next dividend bit.
    logic [31:0]   rem_shift;
    // Quotient bit: either the shifted-out hi[31] makes the 33-bit value exceed any divisor,
    // or the subtract produced no borrow.
    logic          q_bit;

    assign rem_shift = {hi_q[30:0], lo_q[31]};
    assign q_bit     = hi_q[31] | alu_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            op_div_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            op_div_q <= op_div_d;
            dz_q     <= dz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        op_div_d = op_div_q;
        dz_d     = dz_q;
        alu_a    = '0;
        alu_b    = '0;
        alu_func = FUNC_ADD;
        alu_own  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            ST_RUN: begin
                busy    = 1'b1;
                alu_own = 1'b1;
                if (op_div_q) begin
                    alu_func = FUNC_SUB;
                    alu_a    = rem_shift;
                    alu_b    = mcand_q;
                    hi_d     = q_bit ? alu_o : rem_shift;
                    lo_d     = {lo_q[30:0], q_bit};
                end else begin
                    // Shift-add: the carry-out becomes the new top bit of the 64-bit product.
                    alu_func = FUNC_ADD;
                    alu_a    = hi_q;
                    alu_b    = lo_q[0] ? mcand_q : 32'd0;
                    {hi_d, lo_d} = {alu_err, alu_o, lo_q[31:1]};
                end
                count_d = count_q + CW'(1);
                if (count_q == LAST_STEP) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                done = (state_q == ST_DONE);
                if (start) begin
                    mcand_d  = opb;
                    hi_d     = 32'd0;
                    lo_d     = opa;
                    op_div_d = op_div;
                    dz_d     = op_div & (opb == 32'd0);
                    count_d  = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
        endcase
    end

    assign hi = hi_q;
    assign lo = lo_q;
    assign dz = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq driving the real ALU; expected results are hand-computed.
// Latency: results checked in the exact cycle done is expected.
// Backpressure: n/a.
module tb_muldiv_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        op_div = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic [31:0] alu_o;
    logic        alu_err;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_func;
    logic        alu_own;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    muldiv_seq #(.STEPS(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op_div(op_div),
        .opa(opa), .opb(opb), .alu_o(alu_o), .alu_err(alu_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_own(alu_own),
        .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
    );

    alu u_alu (
        .func_i(alu_func), .a_i(alu_a), .b_i(alu_b), .y_o(alu_o), .c32_o(alu_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation, in its cycle.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", {32'd0, hi}, {32'd0, e.hi});
                chk("lo", {32'd0, lo}, {32'd0, e.lo});
                chk("dz", {63'd0, dz}, {63'd0, e.dz});
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called on a negedge; start is presented for one cycle.
    task automatic issue(input logic div, input logic [31:0] a, input logic [31:0] b,
                         input logic expect_done, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic edz);
        exp_t e;
        start  = 1'b1;
        op_div = div;
        opa    = a;
        opb    = b;
        if (expect_done) begin
            e.hi  = ehi;
            e.lo  = elo;
            e.dz  = edz;
            e.cyc = cyc + 33;
            sb.push_back(e);
        end
        @(negedge clk);
        start  = 1'b0;
        opa    = '0;
        opb    = '0;
        op_div = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        // Reset state
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_own", {63'd0, alu_own}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dz", {63'd0, dz}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_func", {58'd0, alu_func}, {58'd0, FUNC_ADD});
        rst = 1'b0;
        @(negedge clk);

        // MULTU 7*6
        issue(1'b0, 32'd7, 32'd6, 1'b1, 32'h0, 32'h2A, 1'b0);
        chk("run_busy", {63'd0, busy}, 64'd1);
        chk("run_own", {63'd0, alu_own}, 64'd1);
        drain();
        chk("idle_busy", {63'd0, busy}, 64'd0);

        // MULTU max*max exercises the carry path
        issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        drain();

        // DIVU cases
        issue(1'b1, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
        drain();
        issue(1'b1, 32'hFFFFFFFF, 32'h80000001, 1'b1, 32'h7FFFFFFE, 32'd1, 1'b0);
        drain();
        issue(1'b1, 32'd5, 32'd7, 1'b1, 32'd5, 32'd0, 1'b0);
        drain();

        // Divide by zero; dz held afterwards
        issue(1'b1, 32'h12345678, 32'd0, 1'b1, 32'h12345678, 32'hFFFFFFFF, 1'b1);
        drain();
        repeat (3) @(negedge clk);
        chk("dz_held", {63'd0, dz}, 64'd1);

        // Start mid-RUN is ignored
        issue(1'b0, 32'h00010000, 32'h00010000, 1'b1, 32'h1, 32'h0, 1'b0);
        repeat (5) @(negedge clk);
        start = 1'b1; op_div = 1'b1; opa = 32'd9; opb = 32'd9;
        @(negedge clk);
        start = 1'b0; op_div = 1'b0; opa = '0; opb = '0;
        drain();

        // Back-to-back: second start lands in the DONE cycle
        issue(1'b1, 32'd1000, 32'd10, 1'b1, 32'd0, 32'd100, 1'b0);
        repeat (32) @(negedge clk);
        issue(1'b0, 32'h12345678, 32'd2, 1'b1, 32'h0, 32'h2468ACF0, 1'b0);
        drain();

        // Reset mid-RUN: asynchronous clear, no done pulse
        issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_own", {63'd0, alu_own}, 64'd0);
        chk("arst_hi", {32'd0, hi}, 64'd0);
        chk("arst_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(1'b0, 32'd3, 32'd5, 1'b1, 32'h0, 32'd15, 1'b0);
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
